// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, bit positions, exception codes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cp0_pkg;

    // Coprocessor-0 register numbers as seen by mtc0/mfc0
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    // SR / Cause field positions
    localparam int IM_HI  = 15;
    localparam int IM_LO  = 10;
    localparam int EXL    = 1;
    localparam int IE     = 0;
    localparam int BD     = 31;
    localparam int EXC_HI = 6;
    localparam int EXC_LO = 2;

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Handler entry, consumed by the fetch mux
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, Compare match latches TimerPend.
// Latency: Count updates every edge; TimerPend sets one edge after Count == Compare.
// Backpressure: none; writes always accepted when the write strobes are high.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wr_count_i          load Count with wdata_i (takes precedence over increment)
//   wr_compare_i        load Compare with wdata_i and clear TimerPend
//   wdata_i             mtc0 write data
//   count_o, compare_o  current register values
//   pend_o              latched timer interrupt
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_count_i,
    input  logic        wr_compare_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        pend_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        pend_q, pend_d;

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        pend_d    = pend_q;
        if (wr_count_i) begin
            count_d = wdata_i;
        end
        if (count_q == compare_q) begin
            pend_d = 1'b1;
        end
        // A Compare write acknowledges the interrupt and wins over a match
        if (wr_compare_i) begin
            compare_d = wdata_i;
            pend_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign pend_o    = pend_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: holds SR/Cause/EPC, raises Req to flush and redirect.
// Latency: Req, CP0Out, EPCOut combinational; register updates take effect next edge.
// Backpressure: none; a mtc0 coinciding with Req is dropped and replayed by the pipeline.
//
// Optional feature macro: CP0_TIMER_EN adds Count (#9) / Compare (#11) and the timer
// interrupt on Cause.IP[15].
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   en           mtc0 write enable; CP0Add selects register, CP0In is data
//   CP0Out       mfc0 read data of CP0Add (pre-edge state)
//   VPC, BDIn    M-stage PC and delay-slot flag of the victim instruction
//   ExcCodeIn    M-stage exception code, 0 = none
//   HWInt        level-sensitive external interrupt lines
//   EXLClr       eret in M stage
//   EPCOut       current EPC for the eret redirect
//   Req          take exception/interrupt this cycle
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = cp0_pkg::HANDLER_PC,
    parameter int          HWINT_W    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [4:0]         CP0Add,
    input  logic [31:0]        CP0In,
    output logic [31:0]        CP0Out,
    input  logic [31:0]        VPC,
    input  logic               BDIn,
    input  logic [4:0]         ExcCodeIn,
    input  logic [HWINT_W-1:0] HWInt,
    input  logic               EXLClr,
    output logic [31:0]        EPCOut,
    output logic               Req
);

    // The handler address lives here only so the fetch mux can pick it up.
    logic unused_handler_pc;
    assign unused_handler_pc = ^HANDLER_PC;

    logic [HWINT_W-1:0] sr_im_q, sr_im_d;
    logic               sr_exl_q, sr_exl_d;
    logic               sr_ie_q, sr_ie_d;
    logic               cause_bd_q, cause_bd_d;
    logic [HWINT_W-1:0] cause_ip_q, cause_ip_d;
    logic [4:0]         cause_exc_q, cause_exc_d;
    logic [31:0]        epc_q, epc_d;

    logic [HWINT_W-1:0] int_lines;
    logic               int_req;
    logic               exc_req;
    logic               wr_ok;

    // Writes are only honoured when no exception is being taken
    assign wr_ok = en & ~Req;

`ifdef CP0_TIMER_EN
    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic        timer_pend;

    cp0_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .wr_count_i   (wr_ok && (CP0Add == REG_COUNT)),
        .wr_compare_i (wr_ok && (CP0Add == REG_COMPARE)),
        .wdata_i      (CP0In),
        .count_o      (count_val),
        .compare_o    (compare_val),
        .pend_o       (timer_pend)
    );

    // Timer shares the top interrupt line with HWInt[HWINT_W-1]
    assign int_lines = HWInt | {timer_pend, {(HWINT_W-1){1'b0}}};
`else
    assign int_lines = HWInt;
`endif

    assign int_req = (|(int_lines & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl_q;
    assign Req     = (int_req | exc_req) & ~reset;

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        // Pending lines are sampled every cycle, whatever else happens
        cause_ip_d  = int_lines;

        if (Req) begin
            sr_exl_d    = 1'b1;
            cause_bd_d  = BDIn;
            cause_exc_d = int_req ? EXC_INT : ExcCodeIn;
            // Delay-slot victims restart at the branch
            epc_d       = BDIn ? (VPC - 32'd4) : VPC;
        end else begin
            if (wr_ok) begin
                case (CP0Add)
                    REG_SR: begin
                        sr_im_d  = CP0In[IM_LO +: HWINT_W];
                        sr_exl_d = CP0In[EXL];
                        sr_ie_d  = CP0In[IE];
                    end
                    REG_EPC: epc_d = CP0In;
                    default: ;
                endcase
            end
            // eret clears EXL after any same-cycle SR write
            if (EXLClr) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    always_comb begin
        CP0Out = '0;
        case (CP0Add)
            REG_SR: begin
                CP0Out[IM_LO +: HWINT_W] = sr_im_q;
                CP0Out[EXL]              = sr_exl_q;
                CP0Out[IE]               = sr_ie_q;
            end
            REG_CAUSE: begin
                CP0Out[BD]               = cause_bd_q;
                CP0Out[IM_LO +: HWINT_W] = cause_ip_q;
                CP0Out[EXC_HI:EXC_LO]    = cause_exc_q;
            end
            REG_EPC: CP0Out = epc_q;
`ifdef CP0_TIMER_EN
            REG_COUNT:   CP0Out = count_val;
            REG_COMPARE: CP0Out = compare_val;
`endif
            default: CP0Out = '0;
        endcase
    end

    assign EPCOut = epc_q;

endmodule
